bcd_scan_counter: RTL

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/bcd_scan_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - 4-digit BCD up/down counter with multiplexed display scan
//
// Purpose: holds a 4-digit BCD count (load / count up / count down / hold),
// raises a one-cycle terminal-count pulse on wrap, and time-multiplexes the
// digits onto a single BCD output for a downstream 7-segment decoder.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         count enable
//   up         direction, 1 = increment, 0 = decrement
//   load       synchronous load strobe (takes priority over en)
//   load_val   load value, four BCD nibbles, [3:0] least significant
//   count      registered BCD count, [3:0] least significant
//   tc         registered one-cycle wrap pulse
//   digit_bcd  BCD digit currently selected by the scan
//   digit_sel  one-hot digit enable, bit0 = least significant digit
module bcd_scan_counter #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic        tc,
    output logic [3:0]  digit_bcd,
    output logic [3:0]  digit_sel
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] prescaler;
    logic [1:0]  scan_idx;
    logic [16:0] step;

    // Nibbles above 9 are forced to 0 so count is always valid BCD.
    function automatic logic [15:0] bcd_sanitize(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd0 : v[4*i +: 4];
        end
        return r;
    endfunction

    // One BCD step with the carry/borrow rippling through all four digits.
    // Bit 16 of the result is the carry/borrow out of the top digit, i.e. the wrap.
    function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic dir_up);
        logic [15:0] r;
        logic [3:0]  d;
        logic        c;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (dir_up) begin
                    if (d == 4'd9) begin
                        d = 4'd0;
                        c = 1'b1;
                    end else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = 4'd9;
                        c = 1'b1;
                    end else begin
                        d = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
            r[4*i +: 4] = d;
        end
        return {c, r};
    endfunction

    assign step = bcd_step(count, up);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'h0000;
            tc    <= 1'b0;
        end else if (load) begin
            count <= bcd_sanitize(load_val);
            tc    <= 1'b0;
        end else if (en) begin
            count <= step[15:0];
            tc    <= step[16];
        end else begin
            tc    <= 1'b0;
        end
    end

    // Free-running scan; digit_sel is rotated in step with scan_idx so it is
    // always the registered one-hot decode of the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= 16'd0;
            scan_idx  <= 2'd0;
            digit_sel <= 4'b0001;
        end else if (prescaler == DIV_LAST) begin
            prescaler <= 16'd0;
            scan_idx  <= scan_idx + 2'd1;
            digit_sel <= {digit_sel[2:0], digit_sel[3]};
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    always_comb begin
        digit_bcd = count[3:0];
        case (scan_idx)
            2'd0: digit_bcd = count[3:0];
            2'd1: digit_bcd = count[7:4];
            2'd2: digit_bcd = count[11:8];
            2'd3: digit_bcd = count[15:12];
            default: digit_bcd = count[3:0];
        endcase
    end

endmodule
